// File: rtl/mips_hazard_scoreboard.sv
// Hazard/forwarding scoreboard for the 5-stage MIPS pipeline: tracks in-flight
// destinations, raises a combinational stall and registers EX-stage forward selects.
module mips_hazard_scoreboard #(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_SRC    = 2,
   parameter int DEPTH      = 3,
   parameter int LOAD_STAGE = 2,
   parameter int RF_BYPASS  = 1,
   parameter int FLUSH_STG  = 1,
   parameter int CNT_W      = 32,
   parameter int SEL_W      = $clog2(DEPTH+1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          id_valid,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
   input  logic [NUM_SRC-1:0]            id_src_used,
   input  logic [REG_ADDR_W-1:0]         id_dst,
   input  logic                          id_wr_en,
   input  logic                          id_is_load,
   input  logic                          flush,
   output logic                          stall,
   output logic                          ex_valid,
   output logic [NUM_SRC*SEL_W-1:0]      ex_fwd_sel,
   output logic [CNT_W-1:0]              stall_cnt
);

   logic [DEPTH-1:0]      r_vld;
   logic [DEPTH-1:0]      r_wr;
   logic [DEPTH-1:0]      r_ld;
   logic [REG_ADDR_W-1:0] r_dst [DEPTH];

   logic [NUM_SRC-1:0]       w_hit;
   logic [NUM_SRC-1:0]       w_hit_ld;
   logic [SEL_W-1:0]         w_hit_k [NUM_SRC];
   logic [NUM_SRC*SEL_W-1:0] w_sel;
   logic                     w_cause;
   logic                     w_push;
   logic [DEPTH-1:0]         w_vld_nxt;

   // Scan oldest to youngest so the youngest producer overwrites older hits.
   always_comb begin
      w_cause  = 1'b0;
      w_sel    = '0;
      w_hit    = '0;
      w_hit_ld = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         w_hit_k[s] = '0;
         for (int k = DEPTH-1; k >= 0; k--) begin
            if (r_vld[k] && r_wr[k] && (r_dst[k] != '0) && id_src_used[s] &&
                (r_dst[k] == id_src[s*REG_ADDR_W +: REG_ADDR_W])) begin
               w_hit[s]    = 1'b1;
               w_hit_ld[s] = r_ld[k];
               w_hit_k[s]  = SEL_W'(k);
            end
         end
         if (w_hit[s]) begin
            if (int'(w_hit_k[s]) + 1 < (w_hit_ld[s] ? LOAD_STAGE : 1))
               w_cause = 1'b1;
            if ((RF_BYPASS == 0) && (int'(w_hit_k[s]) == DEPTH-1))
               w_cause = 1'b1;
            if (int'(w_hit_k[s]) + 1 <= DEPTH-1)
               w_sel[s*SEL_W +: SEL_W] = w_hit_k[s] + SEL_W'(1);
         end
      end
   end

   assign stall  = ~rst & id_valid & ~flush & w_cause;
   assign w_push = id_valid & ~flush & ~stall;

   // Flush squashes the youngest entries after the shift, including the new e[0].
   always_comb begin
      w_vld_nxt    = '0;
      w_vld_nxt[0] = w_push;
      for (int k = 1; k < DEPTH; k++)
         w_vld_nxt[k] = r_vld[k-1];
      for (int k = 0; k < DEPTH; k++)
         if (flush && (k < FLUSH_STG))
            w_vld_nxt[k] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld      <= '0;
         r_wr       <= '0;
         r_ld       <= '0;
         for (int k = 0; k < DEPTH; k++)
            r_dst[k] <= '0;
         ex_valid   <= 1'b0;
         ex_fwd_sel <= '0;
         stall_cnt  <= '0;
      end else begin
         r_vld    <= w_vld_nxt;
         r_wr     <= {r_wr[DEPTH-2:0], id_wr_en};
         r_ld     <= {r_ld[DEPTH-2:0], id_is_load};
         r_dst[0] <= id_dst;
         for (int k = 1; k < DEPTH; k++)
            r_dst[k] <= r_dst[k-1];
         ex_valid   <= w_push;
         ex_fwd_sel <= stall ? '0 : w_sel;
         if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule
